// File: rtl/secuencia_registros.sv
// rtl/secuencia_registros.sv - sequences loading of three registers through the 2-bit select decoder
// Optional macro SECUENCIA_REGISTROS_TIMEOUT_EN enables the wait-state timeout and the error flag.
module secuencia_registros #(
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic       cancelar,
  input  logic       dato_listo,
  output logic [1:0] Contador_Control,
  output logic       escribe,
  output logic [1:0] slot_actual,
  output logic       ocupado,
  output logic       hecho,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ESPERA  = 3'd1,
    ESCRIBE = 3'd2,
    LIBERA  = 3'd3,
    FIN     = 3'd4
  } estado_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  estado_t    estado;
  logic [3:0] cuenta_hold;
  logic       expira;

`ifdef SECUENCIA_REGISTROS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cuenta_to;

  // Expiry is seen on the edge that closes the TIMEOUT_CYCLES-th cycle in a wait state
  assign expira = (cuenta_to == TO_LAST);
`else
  // Without the timeout the wait states may last forever; the parameter is kept for a stable interface
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expira         = 1'b0;
`endif

  // Main controller: state, registered outputs, hold counter and (optionally) timeout counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado           <= IDLE;
      cuenta_hold      <= '0;
      Contador_Control <= 2'b00;
      escribe          <= 1'b0;
      slot_actual      <= 2'b00;
      ocupado          <= 1'b0;
      hecho            <= 1'b0;
      error            <= 1'b0;
`ifdef SECUENCIA_REGISTROS_TIMEOUT_EN
      cuenta_to        <= '0;
`endif
    end else begin
      hecho <= 1'b0;
`ifdef SECUENCIA_REGISTROS_TIMEOUT_EN
      // Cleared by default; only the "stay in wait state" branches advance it
      cuenta_to <= '0;
`endif
      if (estado != IDLE && cancelar) begin
        // Abort beats data, hold completion and timeout; error is left as is
        estado           <= IDLE;
        Contador_Control <= 2'b00;
        escribe          <= 1'b0;
        slot_actual      <= 2'b00;
        ocupado          <= 1'b0;
      end else begin
        case (estado)
          IDLE: begin
            Contador_Control <= 2'b00;
            escribe          <= 1'b0;
            slot_actual      <= 2'b00;
            ocupado          <= 1'b0;
            if (inicio) begin
              estado      <= ESPERA;
              slot_actual <= 2'b01;
              ocupado     <= 1'b1;
              error       <= 1'b0;
            end
          end
          ESPERA: begin
            if (dato_listo) begin
              estado           <= ESCRIBE;
              Contador_Control <= slot_actual;
              escribe          <= 1'b1;
              cuenta_hold      <= '0;
            end else if (expira) begin
              estado      <= IDLE;
              slot_actual <= 2'b00;
              ocupado     <= 1'b0;
              error       <= 1'b1;
            end else begin
`ifdef SECUENCIA_REGISTROS_TIMEOUT_EN
              cuenta_to <= cuenta_to + 1'b1;
`endif
            end
          end
          ESCRIBE: begin
            if (cuenta_hold == HOLD_LAST) begin
              Contador_Control <= 2'b00;
              escribe          <= 1'b0;
              if (slot_actual == 2'b11) begin
                estado <= FIN;
                hecho  <= 1'b1;
              end else begin
                estado <= LIBERA;
              end
            end else begin
              cuenta_hold <= cuenta_hold + 4'd1;
            end
          end
          LIBERA: begin
            // A word is consumed only once dato_listo drops, so a held level loads one slot
            if (!dato_listo) begin
              estado      <= ESPERA;
              slot_actual <= slot_actual + 2'b01;
            end else if (expira) begin
              estado      <= IDLE;
              slot_actual <= 2'b00;
              ocupado     <= 1'b0;
              error       <= 1'b1;
            end else begin
`ifdef SECUENCIA_REGISTROS_TIMEOUT_EN
              cuenta_to <= cuenta_to + 1'b1;
`endif
            end
          end
          FIN: begin
            estado      <= IDLE;
            slot_actual <= 2'b00;
            ocupado     <= 1'b0;
          end
          default: begin
            estado           <= IDLE;
            Contador_Control <= 2'b00;
            escribe          <= 1'b0;
            slot_actual      <= 2'b00;
            ocupado          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_secuencia_registros.sv
// tb/tb_secuencia_registros.sv - directed self-checking bench for secuencia_registros
module tb_secuencia_registros;

`ifdef SECUENCIA_REGISTROS_TIMEOUT_EN
  localparam int TO_CYC  = 10;
  localparam int DL_HELD = 8;
`else
  localparam int TO_CYC  = 1000;
  localparam int DL_HELD = 20;
`endif

  logic       clk;
  logic       reset;
  logic       inicio;
  logic       cancelar;
  logic       dato_listo;
  logic [1:0] Contador_Control;
  logic       escribe;
  logic [1:0] slot_actual;
  logic       ocupado;
  logic       hecho;
  logic       error;

  int total;
  int bad;

  secuencia_registros #(
    .HOLD_CYCLES   (2),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .inicio          (inicio),
    .cancelar        (cancelar),
    .dato_listo      (dato_listo),
    .Contador_Control(Contador_Control),
    .escribe         (escribe),
    .slot_actual     (slot_actual),
    .ocupado         (ocupado),
    .hecho           (hecho),
    .error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chequea(input string tag, input int obs, input int esp);
    total++;
    if (obs != esp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  // one rising edge, then sample 1 time unit later
  task automatic paso();
    @(posedge clk);
    #1;
  endtask

  task automatic chequea_idle(input string tag);
    chequea({tag, ".cc"}, int'(Contador_Control), 0);
    chequea({tag, ".esc"}, int'(escribe), 0);
    chequea({tag, ".slot"}, int'(slot_actual), 0);
    chequea({tag, ".ocup"}, int'(ocupado), 0);
    chequea({tag, ".hecho"}, int'(hecho), 0);
  endtask

  // Full three-slot run: dato_listo 2 high / 3 low, inicio optionally held in [ini_a, ini_b]
  task automatic secuencia(input string tag, input int ini_a, input int ini_b);
    int exp_cc[15]   = '{1,1,0,0,0, 2,2,0,0,0, 3,3,0,0,0};
    int exp_slot[15] = '{1,1,1,2,2, 2,2,2,3,3, 3,3,3,0,0};
    int dl_pat[5]    = '{1,1,0,0,0};
    int hechos;
    hechos = 0;
    inicio = 1'b1;
    paso();
    inicio = 1'b0;
    chequea({tag, ".start_slot"}, int'(slot_actual), 1);
    chequea({tag, ".start_cc"}, int'(Contador_Control), 0);
    chequea({tag, ".start_ocup"}, int'(ocupado), 1);
    for (int i = 0; i < 15; i++) begin
      dato_listo = dl_pat[i % 5][0];
      inicio     = (i >= ini_a && i <= ini_b);
      paso();
      chequea($sformatf("%s.cc[%0d]", tag, i), int'(Contador_Control), exp_cc[i]);
      chequea($sformatf("%s.esc[%0d]", tag, i), int'(escribe), (exp_cc[i] != 0) ? 1 : 0);
      chequea($sformatf("%s.slot[%0d]", tag, i), int'(slot_actual), exp_slot[i]);
      chequea($sformatf("%s.ocup[%0d]", tag, i), int'(ocupado), (i < 13) ? 1 : 0);
      chequea($sformatf("%s.hecho[%0d]", tag, i), int'(hecho), (i == 12) ? 1 : 0);
      if (hecho) hechos++;
    end
    inicio     = 1'b0;
    dato_listo = 1'b0;
    chequea({tag, ".hecho_count"}, hechos, 1);
  endtask

  initial begin
    int escritos;
    int hechos;
    total      = 0;
    bad        = 0;
    reset      = 1'b0;
    inicio     = 1'b0;
    cancelar   = 1'b0;
    dato_listo = 1'b0;

    // reset state
    paso();
    chequea_idle("reset");
    chequea("reset.err", int'(error), 0);
    reset = 1'b1;
    paso();
    chequea_idle("idle");

    // nominal run
    secuencia("seq", -1, -1);

    // reset mid-write discards progress
    inicio = 1'b1;
    paso();
    inicio     = 1'b0;
    dato_listo = 1'b1;
    paso();
    chequea("rst.in_write", int'(Contador_Control), 1);
    reset      = 1'b0;
    dato_listo = 1'b0;
    paso();
    chequea_idle("rst.edge1");
    paso();
    paso();
    chequea_idle("rst.edge3");
    chequea("rst.err", int'(error), 0);
    reset  = 1'b1;
    inicio = 1'b1;
    paso();
    inicio = 1'b0;
    chequea("rst.restart_slot", int'(slot_actual), 1);
    chequea("rst.restart_ocup", int'(ocupado), 1);
    cancelar = 1'b1;
    paso();
    cancelar = 1'b0;
    chequea_idle("rst.cancel");

    // held dato_listo loads one slot only
    inicio = 1'b1;
    paso();
    inicio     = 1'b0;
    dato_listo = 1'b1;
    escritos   = 0;
    for (int i = 0; i < DL_HELD; i++) begin
      paso();
      if (Contador_Control != 2'b00) escritos++;
    end
    chequea("held.writes", escritos, 2);
    chequea("held.slot", int'(slot_actual), 1);
    chequea("held.cc", int'(Contador_Control), 0);
    chequea("held.ocup", int'(ocupado), 1);
    dato_listo = 1'b0;
    paso();
    chequea("held.next_slot", int'(slot_actual), 2);
    cancelar = 1'b1;
    paso();
    cancelar = 1'b0;
    chequea_idle("held.cancel");

    // cancel in the second cycle of the slot-10 write
    inicio = 1'b1;
    paso();
    inicio = 1'b0;
    dato_listo = 1'b1; paso();
    dato_listo = 1'b1; paso();
    dato_listo = 1'b0; paso();
    dato_listo = 1'b0; paso();
    dato_listo = 1'b1; paso();
    chequea("cancel.first_cyc", int'(Contador_Control), 2);
    cancelar = 1'b1;
    paso();
    chequea("cancel.second_cyc_before", 1, 1 - int'(hecho));
    cancelar = 1'b0;
    chequea_idle("cancel");
    hechos = 0;
    for (int i = 0; i < 6; i++) begin
      dato_listo = (i < 2);
      paso();
      if (hecho) hechos++;
      if (Contador_Control != 2'b00) hechos += 10;
    end
    chequea("cancel.quiet_after", hechos, 0);
    dato_listo = 1'b0;

    // inicio during slot 10 is ignored
    secuencia("busy", 3, 7);

    // inicio and cancelar together in IDLE: start wins
    inicio   = 1'b1;
    cancelar = 1'b1;
    paso();
    inicio   = 1'b0;
    cancelar = 1'b0;
    chequea("both.ocup", int'(ocupado), 1);
    chequea("both.slot", int'(slot_actual), 1);
    cancelar = 1'b1;
    paso();
    cancelar = 1'b0;
    chequea_idle("both.cancel");

`ifdef SECUENCIA_REGISTROS_TIMEOUT_EN
    // timeout in ESPERA
    inicio = 1'b1;
    paso();
    inicio = 1'b0;
    for (int i = 0; i < TO_CYC - 1; i++) paso();
    chequea("to.before_ocup", int'(ocupado), 1);
    chequea("to.before_err", int'(error), 0);
    paso();
    chequea("to.err", int'(error), 1);
    chequea("to.ocup", int'(ocupado), 0);
    chequea("to.hecho", int'(hecho), 0);
    paso();
    chequea("to.sticky", int'(error), 1);
    inicio = 1'b1;
    paso();
    inicio = 1'b0;
    chequea("to.cleared", int'(error), 0);
    chequea("to.restart_ocup", int'(ocupado), 1);
`else
    // without the timeout a long wait never aborts
    inicio = 1'b1;
    paso();
    inicio = 1'b0;
    for (int i = 0; i < 40; i++) paso();
    chequea("wait.ocup", int'(ocupado), 1);
    chequea("wait.err", int'(error), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secuencia_registros.md
Name: secuencia_registros

Overview:
- Controller that sequences the loading of the three data registers selected by the 2-bit register-select decoder.
- Drives the decoder's Contador_Control input so that exactly one register is enabled per load window, and 00 (no register) at all other times.
- Handshakes with an upstream data source (keypad/switch capture) one word per slot, in order slot 1 → 2 → 3, then reports completion.
- Sits between the input-capture logic and the register decoder/register bank.

Parameters:
- HOLD_CYCLES, 2, number of clock cycles the register select and write strobe stay active per slot (legal 1..15).
- TIMEOUT_CYCLES, 1000, cycles allowed in a wait state before abort (used only with the optional feature; legal ≥ 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- inicio  input  1  start request, level-sampled, honoured only in IDLE.
- cancelar  input  1  abort request, honoured in any non-IDLE state.
- dato_listo  input  1  upstream word valid for the current slot.
- Contador_Control  output  2  register select to decoder: 00 none, 01/10/11 slot 1/2/3.
- escribe  output  1  write strobe / ack to upstream, high exactly while Contador_Control ≠ 00.
- slot_actual  output  2  slot being waited on or written (01..11), 00 in IDLE.
- ocupado  output  1  high in every state except IDLE.
- hecho  output  1  one-cycle pulse when all three slots are written.
- error  output  1  sticky timeout flag.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clk edge): state=IDLE; Contador_Control=00, escribe=0, slot_actual=00, ocupado=0, hecho=0, error=0; hold and timeout counters cleared. Reset mid-sequence discards progress immediately.
- IDLE: if inicio=1 at an edge → ESPERA, slot=01, ocupado=1, error cleared on the same edge.
- ESPERA: Contador_Control=00.
  - dato_listo=1 at an edge → ESCRIBE. Contador_Control=slot and escribe=1 from that edge (1-cycle latency).
- ESCRIBE: Contador_Control=slot and escribe=1 for exactly HOLD_CYCLES cycles. On the last cycle's edge, Contador_Control=00 and escribe=0, then:
  - slot=11 → FIN.
  - otherwise → LIBERA.
- LIBERA: Contador_Control=00.
  - Waits for dato_listo=0 at an edge, then slot increments and → ESPERA. One word per dato_listo pulse; a held-high dato_listo never loads two slots.
- FIN: hecho=1 for one cycle, ocupado=1 for that cycle; next edge → IDLE with slot_actual=00, ocupado=0.
- cancelar=1 at any edge in ESPERA/ESCRIBE/LIBERA/FIN → IDLE next edge.
  - Contador_Control=00, escribe=0, no hecho, error unchanged.
  - cancelar has priority over dato_listo and over HOLD completion.
- inicio while ocupado=1: ignored. inicio and cancelar together in IDLE: start wins (cancelar is meaningless in IDLE).
- Invariant: Contador_Control ≠ 00 implies escribe=1 and state=ESCRIBE. Never two slots in the same sequence; slots are always written in order 01, 10, 11.

Optional Feature:
- Macro SECUENCIA_REGISTROS_TIMEOUT_EN.
- Defined: a counter runs in ESPERA and LIBERA and is cleared on every state entry. If TIMEOUT_CYCLES consecutive cycles elapse in one such state, the next edge goes → IDLE with error=1 and ocupado=0, no hecho. error holds until reset or the next accepted inicio. cancelar on the same edge as expiry takes priority (IDLE, error unchanged).
- Undefined: no counter is built; wait states may last indefinitely; error is constant 0.

Test Plan:
- Reset held low 3 cycles mid-ESCRIBE → next edge: all outputs 0, Contador_Control=00; a following inicio restarts at slot 01.
- inicio pulse, then three dato_listo pulses (2 cycles high, 3 low), HOLD_CYCLES=2 → Contador_Control sequence 01,01,00…10,10,00…11,11,00; escribe matches; hecho=1 for exactly one cycle; ocupado falls the cycle after.
- dato_listo held high 20 cycles after inicio → only slot 01 written (2 cycles); controller stays in LIBERA with slot_actual=01 until dato_listo drops.
- cancelar asserted during the second cycle of the slot-10 write → next edge: Contador_Control=00, escribe=0, ocupado=0, hecho never pulses.
- inicio asserted while ocupado=1 at slot 10 → no effect; the sequence completes normally with a single hecho.
- With SECUENCIA_REGISTROS_TIMEOUT_EN, TIMEOUT_CYCLES=10, inicio then no dato_listo → after 10 cycles: error=1, ocupado=0. The next inicio clears error on its accepting edge.
